// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the sys_ctrl command sequencer: opcodes, FSM states,
// ALU operand register addresses and the watchdog state classifier.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int REG_ALU_A = 0;
    localparam int REG_ALU_B = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_SEND,
        ST_TX_WAIT
    } state_e;

    // States in which a stalled command is subject to the inter-frame watchdog
    function automatic logic tmo_counts(state_e s);
        return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
                         ST_ALU_A, ST_ALU_B, ST_ALU_FUN, ST_ALU_WAIT};
    endfunction

endpackage

// File: rtl/sys_ctrl_if.sv
// Bundle of RX, register-file, ALU and TX signals around sys_ctrl.
// master = the sequencer side, slave = the surrounding system side.
interface sys_ctrl_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ALU_OUT_W = 16
);
    logic [DATA_W-1:0]    rx_p_data;
    logic                 rx_d_valid;
    logic                 rf_wr_en;
    logic                 rf_rd_en;
    logic [ADDR_W-1:0]    rf_addr;
    logic [DATA_W-1:0]    rf_wr_data;
    logic [DATA_W-1:0]    rf_rd_data;
    logic                 rf_rd_valid;
    logic                 alu_en;
    logic [3:0]           alu_fun;
    logic [ALU_OUT_W-1:0] alu_out;
    logic                 alu_out_valid;
    logic                 clk_gate_en;
    logic [DATA_W-1:0]    tx_p_data;
    logic                 tx_d_valid;
    logic                 tx_busy;

    modport master (
        input  rx_p_data, rx_d_valid, rf_rd_data, rf_rd_valid,
               alu_out, alu_out_valid, tx_busy,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
               clk_gate_en, tx_p_data, tx_d_valid
    );

    modport slave (
        output rx_p_data, rx_d_valid, rf_rd_data, rf_rd_valid,
               alu_out, alu_out_valid, tx_busy,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
               clk_gate_en, tx_p_data, tx_d_valid
    );
endinterface

// File: rtl/sys_ctrl_tx_seq.sv
// Holds a latched result and hands it to the TX serializer byte by byte, LSB first;
// a byte is complete once tx_busy has been seen high and then low again.
module sys_ctrl_tx_seq
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ALU_OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load,
    input  logic                 load_single,
    input  logic [ALU_OUT_W-1:0] load_data,
    input  logic                 send,
    input  logic                 wait_en,
    input  logic                 tx_busy,
    output logic [DATA_W-1:0]    tx_p_data,
    output logic                 tx_d_valid,
    output logic                 byte_done,
    output logic                 last_byte
);
    localparam int NB    = ALU_OUT_W / DATA_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [ALU_OUT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     last_q, last_d;
    logic                 saw_busy_q, saw_busy_d;
    logic [DATA_W-1:0]    tx_p_data_q, tx_p_data_d;
    logic                 tx_d_valid_q, tx_d_valid_d;
    logic [DATA_W-1:0]    bytes [NB];

    for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
        assign bytes[gi] = data_q[gi*DATA_W +: DATA_W];
    end

    assign byte_done  = wait_en && saw_busy_q && !tx_busy;
    assign last_byte  = (cnt_q == last_q);
    assign tx_p_data  = tx_p_data_q;
    assign tx_d_valid = tx_d_valid_q;

    always_comb begin
        data_d       = data_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        saw_busy_d   = saw_busy_q;
        tx_p_data_d  = tx_p_data_q;
        tx_d_valid_d = 1'b0;
        if (load) begin
            data_d = load_data;
            cnt_d  = '0;
            last_d = load_single ? '0 : CNT_W'(NB - 1);
        end
        if (send) begin
            tx_p_data_d  = bytes[cnt_q];
            tx_d_valid_d = 1'b1;
            saw_busy_d   = 1'b0;
        end
        if (wait_en && tx_busy) begin
            saw_busy_d = 1'b1;
        end
        if (byte_done) begin
            cnt_d      = cnt_q + 1'b1;
            saw_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q       <= '0;
            cnt_q        <= '0;
            last_q       <= '0;
            saw_busy_q   <= 1'b0;
            tx_p_data_q  <= '0;
            tx_d_valid_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            saw_busy_q   <= saw_busy_d;
            tx_p_data_q  <= tx_p_data_d;
            tx_d_valid_q <= tx_d_valid_d;
        end
    end
endmodule

// File: rtl/sys_ctrl.sv
// Byte-framed command sequencer driving the register file, ALU and TX path.
// Optional inter-frame watchdog enabled with `define SYS_CTRL_TIMEOUT_EN.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ALU_OUT_W = 16
`ifdef SYS_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic        Ref_clk,
    input  logic        rst,
    sys_ctrl_if.master  bus
);
    localparam logic [ADDR_W-1:0] ADDR_A = ADDR_W'(REG_ALU_A);
    localparam logic [ADDR_W-1:0] ADDR_B = ADDR_W'(REG_ALU_B);

    state_e               state_q, state_d;
    logic                 rf_wr_en_q, rf_wr_en_d;
    logic                 rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_W-1:0]    rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]    rf_wr_data_q, rf_wr_data_d;
    logic                 alu_en_q, alu_en_d;
    logic [3:0]           alu_fun_q, alu_fun_d;
    logic                 clk_gate_en_q, clk_gate_en_d;
    logic                 tx_load, tx_single, tx_send, tx_wait;
    logic                 tx_byte_done, tx_last_byte;
    logic [ALU_OUT_W-1:0] tx_load_data;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d      = state_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        tx_load      = 1'b0;
        tx_single    = 1'b0;
        tx_send      = 1'b0;
        tx_wait      = 1'b0;
        tx_load_data = bus.alu_out;
        case (state_q)
            ST_IDLE: if (bus.rx_d_valid) begin
                case (bus.rx_p_data)
                    CMD_RF_WR:   state_d = ST_WR_ADDR;
                    CMD_RF_RD:   state_d = ST_RD_ADDR;
                    CMD_ALU_OP:  state_d = ST_ALU_A;
                    CMD_ALU_NOP: state_d = ST_ALU_FUN;
                    default:     state_d = ST_IDLE;
                endcase
            end
            ST_WR_ADDR: if (bus.rx_d_valid) begin
                rf_addr_d = bus.rx_p_data[ADDR_W-1:0];
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: if (bus.rx_d_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_wr_data_d = bus.rx_p_data;
                state_d      = ST_IDLE;
            end
            ST_RD_ADDR: if (bus.rx_d_valid) begin
                rf_addr_d  = bus.rx_p_data[ADDR_W-1:0];
                rf_rd_en_d = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (bus.rf_rd_valid) begin
                tx_load      = 1'b1;
                tx_single    = 1'b1;
                tx_load_data = {{(ALU_OUT_W-DATA_W){1'b0}}, bus.rf_rd_data};
                state_d      = ST_TX_SEND;
            end
            ST_ALU_A: if (bus.rx_d_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_addr_d    = ADDR_A;
                rf_wr_data_d = bus.rx_p_data;
                state_d      = ST_ALU_B;
            end
            ST_ALU_B: if (bus.rx_d_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_addr_d    = ADDR_B;
                rf_wr_data_d = bus.rx_p_data;
                state_d      = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (bus.rx_d_valid) begin
                alu_fun_d = bus.rx_p_data[3:0];
                alu_en_d  = 1'b1;
                state_d   = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (bus.alu_out_valid) begin
                tx_load = 1'b1;
                state_d = ST_TX_SEND;
            end
            ST_TX_SEND: if (!bus.tx_busy) begin
                tx_send = 1'b1;
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                tx_wait = 1'b1;
                if (tx_byte_done) begin
                    state_d = tx_last_byte ? ST_IDLE : ST_TX_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SYS_CTRL_TIMEOUT_EN
        // A stalled command is abandoned outright: strobes and latches are undone too
        if (tmo_counts(state_q) && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d      = ST_IDLE;
            rf_wr_en_d   = 1'b0;
            rf_rd_en_d   = 1'b0;
            alu_en_d     = 1'b0;
            rf_addr_d    = rf_addr_q;
            rf_wr_data_d = rf_wr_data_q;
            alu_fun_d    = alu_fun_q;
            tx_load      = 1'b0;
        end
        tmo_d = (tmo_counts(state_d) && state_d == state_q) ? tmo_q + 1'b1 : '0;
`endif
        clk_gate_en_d = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);
    end

    always_ff @(posedge Ref_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            rf_addr_q     <= '0;
            rf_wr_data_q  <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rf_wr_en_q    <= rf_wr_en_d;
            rf_rd_en_q    <= rf_rd_en_d;
            rf_addr_q     <= rf_addr_d;
            rf_wr_data_q  <= rf_wr_data_d;
            alu_en_q      <= alu_en_d;
            alu_fun_q     <= alu_fun_d;
            clk_gate_en_q <= clk_gate_en_d;
        end
    end

`ifdef SYS_CTRL_TIMEOUT_EN
    always_ff @(posedge Ref_clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign bus.rf_wr_en    = rf_wr_en_q;
    assign bus.rf_rd_en    = rf_rd_en_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wr_data  = rf_wr_data_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_fun     = alu_fun_q;
    assign bus.clk_gate_en = clk_gate_en_q;

    sys_ctrl_tx_seq #(
        .DATA_W    (DATA_W),
        .ALU_OUT_W (ALU_OUT_W)
    ) u_tx_seq (
        .clk         (Ref_clk),
        .srst        (rst),
        .load        (tx_load),
        .load_single (tx_single),
        .load_data   (tx_load_data),
        .send        (tx_send),
        .wait_en     (tx_wait),
        .tx_busy     (bus.tx_busy),
        .tx_p_data   (bus.tx_p_data),
        .tx_d_valid  (bus.tx_d_valid),
        .byte_done   (tx_byte_done),
        .last_byte   (tx_last_byte)
    );
endmodule
